// File: rtl/mips_dbg_pkg.sv
// Shared types for the MIPS debug/run-control blocks.
package mips_dbg_pkg;

    localparam int NREG_MAX = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_RUN,
        ST_DUMP_ADDR,
        ST_DUMP_BEAT,
        ST_DONE
    } run_state_e;

endpackage

// File: rtl/mips_run_ctrl.sv
// Run controller for the single-cycle MIPS core: repeated reset/run sequences with
// halt-PC / cycle-budget stop, then a valid/ready register-file dump via read port 3.
module mips_run_ctrl
    import mips_dbg_pkg::*;
#(
    parameter int PC_W       = 32,
    parameter int CYC_W      = 16,
    parameter int RUN_W      = 4,
    parameter int RST_CYCLES = 2,
    parameter int NREG       = 32,
    parameter int DUMP_EN    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PC_W-1:0]  halt_pc,
    input  logic [CYC_W-1:0] max_cycles,
    input  logic [RUN_W-1:0] num_runs,
    input  logic [PC_W-1:0]  pc_current,
    input  logic [31:0]      rd3,
    input  logic             dump_ready,
    output logic             cpu_rst,
    output logic             cpu_en,
    output logic [4:0]       ra3,
    output logic             busy,
    output logic             done,
    output logic             halted,
    output logic             timeout,
    output logic [CYC_W-1:0] cycles,
    output logic [RUN_W-1:0] run_idx,
    output logic             dump_valid,
    output logic [4:0]       dump_idx,
    output logic [31:0]      dump_data
);

    localparam int         NREG_C   = (NREG > NREG_MAX) ? NREG_MAX : NREG;
    localparam logic [4:0] LAST_REG = 5'(NREG_C - 1);
    localparam int         RC_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0] RST_LAST = RC_W'(RST_CYCLES - 1);

    run_state_e       state_q, state_d;
    logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [RUN_W-1:0] run_idx_q, run_idx_d;
    logic [CYC_W-1:0] cycles_q, cycles_d;
    logic             halted_q, halted_d;
    logic             timeout_q, timeout_d;
    logic [4:0]       dump_idx_q, dump_idx_d;
    logic             dump_valid_q, dump_valid_d;
    logic [31:0]      dump_data_q, dump_data_d;

    logic             halt_hit, budget_hit, last_run, run_en;
    logic [RUN_W-1:0] last_idx;

    assign halt_hit   = (pc_current == halt_pc);
    assign budget_hit = (cycles_q == max_cycles);
    assign last_idx   = (num_runs == '0) ? '0 : num_runs - 1'b1;
    assign last_run   = (run_idx_q == last_idx);

    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        run_idx_d    = run_idx_q;
        cycles_d     = cycles_q;
        halted_d     = halted_q;
        timeout_d    = timeout_q;
        dump_idx_d   = dump_idx_q;
        dump_valid_d = dump_valid_q;
        dump_data_d  = dump_data_q;
        run_en       = 1'b0;
        ra3          = '0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_RESET;
                    rst_cnt_d  = '0;
                    run_idx_d  = '0;
                    cycles_d   = '0;
                    halted_d   = 1'b0;
                    timeout_d  = 1'b0;
                    dump_idx_d = '0;
                end
            end
            ST_RESET: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d  = ST_RUN;
                    cycles_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                // PC match outranks the budget so max_cycles==0 with a matching PC is a clean halt
                if (halt_hit || budget_hit) begin
                    if (!halt_hit) timeout_d = 1'b1;
                    if (!last_run) begin
                        run_idx_d = run_idx_q + 1'b1;
                        rst_cnt_d = '0;
                        state_d   = ST_RESET;
                    end else begin
                        halted_d = halt_hit;
                        state_d  = (DUMP_EN != 0) ? ST_DUMP_ADDR : ST_DONE;
                    end
                end else begin
                    run_en = 1'b1;
                    if (cycles_q != '1) cycles_d = cycles_q + 1'b1;
                end
            end
            ST_DUMP_ADDR: begin
                ra3          = dump_idx_q;
                dump_data_d  = rd3;
                dump_valid_d = 1'b1;
                state_d      = ST_DUMP_BEAT;
            end
            ST_DUMP_BEAT: begin
                if (dump_valid_q && dump_ready) begin
                    dump_valid_d = 1'b0;
                    if (dump_idx_q == LAST_REG) begin
                        state_d = ST_DONE;
                    end else begin
                        dump_idx_d = dump_idx_q + 1'b1;
                        state_d    = ST_DUMP_ADDR;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rst_cnt_q    <= '0;
            run_idx_q    <= '0;
            cycles_q     <= '0;
            halted_q     <= 1'b0;
            timeout_q    <= 1'b0;
            dump_idx_q   <= '0;
            dump_valid_q <= 1'b0;
            dump_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            run_idx_q    <= run_idx_d;
            cycles_q     <= cycles_d;
            halted_q     <= halted_d;
            timeout_q    <= timeout_d;
            dump_idx_q   <= dump_idx_d;
            dump_valid_q <= dump_valid_d;
            dump_data_q  <= dump_data_d;
        end
    end

    // The core must not advance in the cycle the controller itself is being reset
    assign cpu_en     = run_en && !rst;
    assign cpu_rst    = rst || (state_q == ST_RESET);
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done       = (state_q == ST_DONE);
    assign halted     = halted_q;
    assign timeout    = timeout_q;
    assign cycles     = cycles_q;
    assign run_idx    = run_idx_q;
    assign dump_valid = dump_valid_q;
    assign dump_idx   = dump_idx_q;
    assign dump_data  = dump_data_q;

endmodule
